systolic_mm_nxn: RTL and testbench
==================================

# systolic_mm_nxn

Parametrised N×N output-stationary FP32 systolic matrix multiplier with its own control. It accepts A-columns and B-rows as unskewed vectors, skews them internally, accumulates C = A·B over a runtime inner dimension `k_len`, then streams C out row by row over a valid/ready handshake. It replaces fixed-size arrays driven by hand-skewed benches, sitting between an operand buffer and a result sink.

## Interface
- `N`, 4: array dimension (2..8); C is N×N.
- `KW`, 8: width of `k_len`; max inner dimension 2^KW−1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  begin a job; sampled only in IDLE.
- `k_len`  in  KW  inner dimension, sampled with `start`.
- `accum`  in  1  keep previous C (see Configuration).
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  high in LOAD only.
- `a_col`  in  N*32  A[i][k] at bits [i*32 +: 32].
- `b_row`  in  N*32  B[k][j] at bits [j*32 +: 32].
- `out_valid`  out  1  result row present.
- `out_ready`  in  1  sink accepts row.
- `out_row`  out  N*32  C[r][j] at bits [j*32 +: 32].
- `out_idx`  out  clog2(N)  row index r.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse after last row accepted.

## Operation
- FSM: IDLE → LOAD → DRAIN → OUT → IDLE.
- IDLE: `start` with `k_len`≥1 → LOAD; accumulators cleared to +0 on that edge (unless accumulate mode). `start` with `k_len`=0 ignored; `start` outside IDLE ignored.
- LOAD: each `in_valid && in_ready` edge is one beat; beat counter counts to `k_len`, then → DRAIN. Cycles without `in_valid` inject zero operands (bubbles allowed).
- Skew: lane i of A delayed i cycles, lane j of B delayed j cycles via registers; skew registers load zero when no beat.
- PE(i,j): registers a→east, b→south; `acc <= fp_add(acc, fp_mul(a_in, b_in))` each cycle using the existing single-cycle FP32 multiplier/adder; rounding/special cases as those units define.
- DRAIN: fixed 2N−1 cycles, zeros injected; then → OUT.
- OUT: rows r = 0..N−1; `out_row`, `out_idx` held stable while `out_valid && !out_ready`; row advances on handshake. After row N−1 accepted → IDLE, `done`=1 that next cycle.
- `in_valid` outside LOAD ignored; `out_ready` outside OUT ignored.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_row`=0, `out_idx`=0, `busy`=0, `done`=0; FSM IDLE; all PE/skew registers and accumulators +0.
- `start` at edge S → LOAD, `in_ready`=1 from S+1.
- Last beat accepted at edge T → `out_valid`=1 from cycle T+2N; with no backpressure rows occupy T+2N..T+3N−1, `done` at T+3N.
- Reset during any state: next cycle matches reset values, partial job discarded.
- Throughput: one beat per cycle in LOAD, one row per cycle in OUT.

## Configuration
- `SYSTOLIC_ACCUMULATE_EN` defined: `start` with `accum`=1 keeps accumulators, giving C += A·B; `accum`=0 clears.
- Undefined: `accum` ignored; accumulators always cleared on `start`.

## Test plan
- N=2, k_len=2, A=B=[[0.5,0.25],[0.125,0.5]] back-to-back beats → rows [3E900000,3E800000], [3E000000,3E900000]; `out_valid` exactly 4 cycles after last beat.
- N=4, k_len=4, A=identity, B[i][j]=i*4+j as FP32 → C equals B; `done` one cycle after row 3.
- Same N=2 job with `in_valid` low on alternate cycles and `out_ready` low 3 cycles on row 0 → identical results, `out_row` stable while stalled, no row lost or duplicated.
- `SYSTOLIC_ACCUMULATE_EN`: run N=2 job twice, second with `accum`=1 → C doubled (3F100000, 3F000000, 3E800000, 3F100000); macro undefined → unchanged.
- Reset asserted mid-LOAD after 1 of 3 beats → next cycle `busy`=0, `in_ready`=0; new job yields correct C, no residue.
- `start` with `k_len`=0, and `start` pulsed during DRAIN → both ignored, state unchanged.

Source files
------------

// File: rtl/systolic_mm_nxn.sv
// N x N output-stationary FP32 systolic multiplier with internal operand skew and row-wise result streaming.
// Define SYSTOLIC_ACCUMULATE_EN to let `start` with `accum`=1 keep the previous C (C += A*B).
module systolic_mm_nxn #(
    parameter int N  = 4,
    parameter int KW = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            accum,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*32-1:0] a_col,
    input  logic [N*32-1:0] b_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*32-1:0] out_row,
    output logic [IW-1:0]   out_idx,
    output logic            busy,
    output logic            done
);
    localparam int DW = $clog2(2 * N);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    // FP32 multiply: denormals flush to zero, mantissa truncated, overflow saturates to infinity.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic              s;
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [22:0]       m;
        s = x[31] ^ y[31];
        p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
        e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'sd1;
        end else begin
            m = p[45:23];
        end
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || e <= 0) return {s, 31'd0};
        if (e >= 10'sd255) return {s, 8'hff, 23'd0};
        return {s, e[7:0], m};
    endfunction

    // FP32 add with the same truncation and flush rules; a zero operand passes the other through.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       hi, lo;
        logic [7:0]        d;
        logic [23:0]       ml;
        logic [24:0]       sum;
        logic signed [9:0] e;
        logic [22:0]       m;
        if (x[30:23] == 8'd0) return y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:0] >= y[30:0]) begin
            hi = x;
            lo = y;
        end else begin
            hi = y;
            lo = x;
        end
        d  = hi[30:23] - lo[30:23];
        ml = (d > 8'd23) ? 24'd0 : ({1'b1, lo[22:0]} >> d);
        e  = $signed({2'b00, hi[30:23]});
        if (hi[31] == lo[31]) begin
            sum = {2'b01, hi[22:0]} + {1'b0, ml};
            if (sum[24]) begin
                m = sum[23:1];
                e = e + 10'sd1;
            end else begin
                m = sum[22:0];
            end
        end else begin
            sum = {2'b01, hi[22:0]} - {1'b0, ml};
            if (sum == 25'd0) return 32'd0;
            for (int k = 0; k < 24; k++) begin
                if (!sum[23]) begin
                    sum = sum << 1;
                    e   = e - 10'sd1;
                end
            end
            m = sum[22:0];
        end
        if (e <= 0) return {hi[31], 31'd0};
        if (e >= 10'sd255) return {hi[31], 8'hff, 23'd0};
        return {hi[31], e[7:0], m};
    endfunction

    logic [1:0]    state;
    logic [KW-1:0] k_q;
    logic [KW-1:0] beat_cnt;
    logic [DW-1:0] drain_cnt;
    logic          beat;
    logic          start_ok;
    logic          clear_acc;
    logic [31:0]   a_skew [N];
    logic [31:0]   b_skew [N];
    logic [31:0]   pe_a   [N][N];
    logic [31:0]   pe_b   [N][N];
    logic [31:0]   acc    [N][N];

    // Handshakes: an operand beat transfers on a rising edge with in_valid && in_ready; a result row
    // transfers with out_valid && out_ready, and out_row/out_idx hold while out_valid && !out_ready.
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign beat      = in_valid && in_ready;
    assign start_ok  = (state == S_IDLE) && start && (k_len != '0);

`ifdef SYSTOLIC_ACCUMULATE_EN
    assign clear_acc = start_ok && !accum;
`else
    logic unused_accum;
    assign unused_accum = accum;
    assign clear_acc    = start_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start_ok) begin
                    state    <= S_LOAD;
                    k_q      <= k_len;
                    beat_cnt <= '0;
                end
                S_LOAD: if (beat) begin
                    if (beat_cnt == k_q - KW'(1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + KW'(1);
                    end
                end
                S_DRAIN: if (drain_cnt == DW'(2 * N - 2)) begin
                    state   <= S_OUT;
                    out_idx <= '0;
                end else begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                S_OUT: if (out_ready) begin
                    if (out_idx == IW'(N - 1)) begin
                        state   <= S_IDLE;
                        out_idx <= '0;
                        done    <= 1'b1;
                    end else begin
                        out_idx <= out_idx + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Lane i passes through i+1 registers, so each lane lags lane 0 by i cycles.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [31:0] sa [i+1];
        logic [31:0] sb [i+1];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    sa[s] <= '0;
                    sb[s] <= '0;
                end
            end else begin
                sa[0] <= beat ? a_col[i*32 +: 32] : 32'd0;
                sb[0] <= beat ? b_row[i*32 +: 32] : 32'd0;
                for (int s = 1; s <= i; s++) begin
                    sa[s] <= sa[s-1];
                    sb[s] <= sb[s-1];
                end
            end
        end
        assign a_skew[i] = sa[i];
        assign b_skew[i] = sb[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [31:0] a_in, b_in;
            if (j == 0) begin : g_a_edge
                assign a_in = a_skew[i];
            end else begin : g_a_mid
                assign a_in = pe_a[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_skew[j];
            end else begin : g_b_mid
                assign b_in = pe_b[i-1][j];
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    pe_a[i][j] <= '0;
                    pe_b[i][j] <= '0;
                    acc[i][j]  <= '0;
                end else begin
                    pe_a[i][j] <= a_in;
                    pe_b[i][j] <= b_in;
                    if (clear_acc) acc[i][j] <= '0;
                    else           acc[i][j] <= fp_add(acc[i][j], fp_mul(a_in, b_in));
                end
            end
        end
    end

    always_comb begin
        out_row = '0;
        if (state == S_OUT) begin
            for (int j = 0; j < N; j++) out_row[j*32 +: 32] = acc[out_idx][j];
        end
    end
endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Directed bench for systolic_mm_nxn: an N=2 instance for handshake/control cases and an N=4 instance
// for the identity job; expected rows are hand-computed FP32 constants held in an expected queue.
module tb_systolic_mm_nxn;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic         start2, accum2, in_valid2, in_ready2, out_valid2, out_ready2, busy2, done2;
    logic [7:0]   k_len2;
    logic [63:0]  a_col2, b_row2, out_row2;
    logic [0:0]   out_idx2;
    logic         start4, accum4, in_valid4, in_ready4, out_valid4, out_ready4, busy4, done4;
    logic [7:0]   k_len4;
    logic [127:0] a_col4, b_row4, out_row4;
    logic [1:0]   out_idx4;

    logic [63:0]  exp_q[$];
    logic [127:0] exp4_q[$];

    systolic_mm_nxn #(.N(2), .KW(8)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .k_len(k_len2), .accum(accum2),
        .in_valid(in_valid2), .in_ready(in_ready2), .a_col(a_col2), .b_row(b_row2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_row(out_row2), .out_idx(out_idx2),
        .busy(busy2), .done(done2)
    );

    systolic_mm_nxn #(.N(4), .KW(8)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .k_len(k_len4), .accum(accum4),
        .in_valid(in_valid4), .in_ready(in_ready4), .a_col(a_col4), .b_row(b_row4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_row(out_row4), .out_idx(out_idx4),
        .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // A = B = [[0.5,0.25],[0.125,0.5]]; column k of A and row k of B, lane 0 in the low word.
    localparam logic [63:0] A_COL0 = {32'h3E000000, 32'h3F000000};
    localparam logic [63:0] A_COL1 = {32'h3F000000, 32'h3E800000};
    localparam logic [63:0] B_ROW0 = {32'h3E800000, 32'h3F000000};
    localparam logic [63:0] B_ROW1 = {32'h3F000000, 32'h3E000000};

    task automatic run2(input bit gaps, input int stall, input bit acc_mode, input bit drain_poke);
        logic [63:0] a_cols [2];
        logic [63:0] b_rows [2];
        logic [63:0] held;
        int cnt;
        a_cols[0] = A_COL0; a_cols[1] = A_COL1;
        b_rows[0] = B_ROW0; b_rows[1] = B_ROW1;
        start2 = 1'b1; k_len2 = 8'd2; accum2 = acc_mode;
        tick();
        start2 = 1'b0; accum2 = 1'b0;
        check("load_ready", {127'd0, in_ready2}, 128'd1);
        for (int k = 0; k < 2; k++) begin
            if (gaps) begin
                in_valid2 = 1'b0;
                tick();
            end
            in_valid2 = 1'b1; a_col2 = a_cols[k]; b_row2 = b_rows[k];
            tick();
        end
        in_valid2 = 1'b0; a_col2 = '0; b_row2 = '0;
        cnt = 1;
        while (!out_valid2 && cnt < 40) begin
            if (drain_poke && cnt == 1) begin
                start2 = 1'b1; k_len2 = 8'd2; in_valid2 = 1'b1; a_col2 = {2{32'h40000000}}; b_row2 = {2{32'h40000000}};
            end else begin
                start2 = 1'b0; in_valid2 = 1'b0; a_col2 = '0; b_row2 = '0;
            end
            tick();
            cnt++;
            if (drain_poke && cnt == 2) begin
                check("poke_busy", {127'd0, busy2}, 128'd1);
                check("poke_ready", {127'd0, in_ready2}, 128'd0);
            end
        end
        start2 = 1'b0; in_valid2 = 1'b0;
        check("latency2", 128'(cnt), 128'd4);
        for (int r = 0; r < 2; r++) begin
            if (r == 0 && stall > 0) begin
                out_ready2 = 1'b0;
                held = out_row2;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check("stall_valid", {127'd0, out_valid2}, 128'd1);
                    check("stall_row", {64'd0, out_row2}, {64'd0, held});
                    check("stall_idx", {127'd0, out_idx2}, 128'd0);
                end
            end
            out_ready2 = 1'b1;
            check("row_idx", {127'd0, out_idx2}, 128'(r));
            if (exp_q.size() == 0) check("exp_q_empty", 128'd1, 128'd0);
            else check("row_data", {64'd0, out_row2}, {64'd0, exp_q.pop_front()});
            tick();
        end
        out_ready2 = 1'b0;
        check("done_pulse", {127'd0, done2}, 128'd1);
        check("idle_busy", {127'd0, busy2}, 128'd0);
        check("idle_valid", {127'd0, out_valid2}, 128'd0);
        tick();
        check("done_clear", {127'd0, done2}, 128'd0);
    endtask

    task automatic push_base();
        exp_q.push_back({32'h3E800000, 32'h3E900000});
        exp_q.push_back({32'h3E900000, 32'h3E000000});
    endtask

    logic [31:0] fval [16];
    int cnt4;

    initial begin
        fval = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
                 32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
                 32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
        reset = 1'b1;
        start2 = 0; k_len2 = 0; accum2 = 0; in_valid2 = 0; a_col2 = '0; b_row2 = '0; out_ready2 = 0;
        start4 = 0; k_len4 = 0; accum4 = 0; in_valid4 = 0; a_col4 = '0; b_row4 = '0; out_ready4 = 0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", {126'd0, in_ready2, in_ready4}, 128'd0);
        check("rst_valid", {126'd0, out_valid2, out_valid4}, 128'd0);
        check("rst_busy", {126'd0, busy2, busy4}, 128'd0);
        check("rst_done", {126'd0, done2, done4}, 128'd0);
        check("rst_row2", {64'd0, out_row2}, 128'd0);
        check("rst_row4", out_row4, 128'd0);
        check("rst_idx", {125'd0, out_idx2, out_idx4}, 128'd0);

        // Basic job, back-to-back beats.
        push_base();
        run2(1'b0, 0, 1'b0, 1'b0);

        // Same job with bubbles and output backpressure on row 0.
        push_base();
        run2(1'b1, 3, 1'b0, 1'b0);

        // Two jobs, the second asking to accumulate.
        push_base();
        run2(1'b0, 0, 1'b0, 1'b0);
`ifdef SYSTOLIC_ACCUMULATE_EN
        exp_q.push_back({32'h3F000000, 32'h3F100000});
        exp_q.push_back({32'h3F100000, 32'h3E800000});
`else
        push_base();
`endif
        run2(1'b0, 0, 1'b1, 1'b0);

        // Reset after one of three beats, then a clean job.
        start2 = 1'b1; k_len2 = 8'd3;
        tick();
        start2 = 1'b0;
        in_valid2 = 1'b1; a_col2 = {2{32'h3F800000}}; b_row2 = {2{32'h3F800000}};
        tick();
        in_valid2 = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", {127'd0, busy2}, 128'd0);
        check("mid_rst_ready", {127'd0, in_ready2}, 128'd0);
        check("mid_rst_row", {64'd0, out_row2}, 128'd0);
        push_base();
        run2(1'b0, 0, 1'b0, 1'b0);

        // start with k_len=0 is ignored.
        start2 = 1'b1; k_len2 = 8'd0;
        tick();
        start2 = 1'b0;
        check("k0_busy", {127'd0, busy2}, 128'd0);
        check("k0_ready", {127'd0, in_ready2}, 128'd0);
        tick();
        check("k0_busy_later", {127'd0, busy2}, 128'd0);

        // start and in_valid during DRAIN are ignored.
        push_base();
        run2(1'b0, 0, 1'b0, 1'b1);
        tick();
        check("poke_no_job", {127'd0, busy2}, 128'd0);

        // N=4: identity times B where B[i][j] = i*4+j.
        start4 = 1'b1; k_len4 = 8'd4;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1'b1;
            a_col4 = '0;
            a_col4[k*32 +: 32] = 32'h3F800000;
            for (int j = 0; j < 4; j++) b_row4[j*32 +: 32] = fval[k*4 + j];
            tick();
        end
        in_valid4 = 1'b0; a_col4 = '0; b_row4 = '0;
        for (int r = 0; r < 4; r++)
            exp4_q.push_back({fval[r*4+3], fval[r*4+2], fval[r*4+1], fval[r*4]});
        cnt4 = 1;
        while (!out_valid4 && cnt4 < 40) begin
            tick();
            cnt4++;
        end
        check("latency4", 128'(cnt4), 128'd8);
        out_ready4 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            check("row4_idx", {126'd0, out_idx4}, 128'(r));
            check("row4_valid", {127'd0, out_valid4}, 128'd1);
            check("row4_data", out_row4, exp4_q.pop_front());
            if (r < 3) check("done4_early", {127'd0, done4}, 128'd0);
            tick();
        end
        out_ready4 = 1'b0;
        check("done4_pulse", {127'd0, done4}, 128'd1);
        check("busy4_idle", {127'd0, busy4}, 128'd0);
        tick();
        check("done4_clear", {127'd0, done4}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
